fringe_comparator: RTL and testbench

- Consumes the sample stream and the adaptive upper/lower thresholds produced directly upstream by the extremum finder.
- Applies a hysteresis (Schmitt) comparator to each sample, which digitises the interferometer signal into a full-scale square wave.
- Counts rising fringes and measures the fringe period in samples.
- Output stream feeds the DAC/decimation path; count and period are exposed as status registers to the AXI-lite register block.

---
 rtl/fringe_comparator_pkg.sv | 28 ++
 rtl/fringe_comparator_if.sv | 22 ++
 rtl/fringe_comparator_schmitt_trigger.sv | 68 ++++++
 rtl/fringe_comparator.sv | 121 ++++++++++++
 tb/tb_fringe_comparator.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fringe_comparator_pkg.sv
// Shared types and constants for the fringe comparator: comparator state
// encoding and full-scale output codes.
package fringe_comparator_pkg;

  typedef enum logic [1:0] {
    INIT = 2'b00,
    LOW  = 2'b01,
    HIGH = 2'b10
  } fc_state_t;

  localparam int FC_REG_WIDTH = 32;

  // Full-scale codes are returned 64 bits wide; callers slice to their width.
  function automatic logic [63:0] pos_fs(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] neg_fs(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // Signed "upper strictly above lower" test on w-bit thresholds.
  function automatic logic thresholds_ok(input logic signed [63:0] upper,
                                         input logic signed [63:0] lower);
    return upper > lower;
  endfunction

endpackage

// File: rtl/fringe_comparator_if.sv
// AXI-Stream style sample channel used on both sides of the fringe comparator.
// A beat transfers on every cycle where tvalid and tready are both 1; the
// source must hold tdata stable while tvalid is 1 and tready is 0.
interface fringe_comparator_if #(
  parameter int W = 32
);
  logic         tvalid;
  logic [W-1:0] tdata;
  logic         tready;

  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/fringe_comparator_schmitt_trigger.sv
// Hysteresis comparator: state register plus next-state and rising-fringe
// logic; state only moves on valid samples.
module schmitt_trigger
  import fringe_comparator_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic signed [W-1:0] sample,
  input  logic signed [W-1:0] upper,
  input  logic signed [W-1:0] lower,
  output fc_state_t           state_q,
  output fc_state_t           state_d,
  output logic                rise,
  output logic                thr_ok
);

  logic signed [63:0] upper_ext;
  logic signed [63:0] lower_ext;

  assign upper_ext = 64'(upper);
  assign lower_ext = 64'(lower);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rise    = 1'b0;
    thr_ok  = thresholds_ok(upper_ext, lower_ext);
    if (sample_valid) begin
      if (!thr_ok) begin
        state_d = INIT;
      end else begin
        unique case (state_q)
          INIT: begin
            // Leaving INIT upward is an acquisition, not a fringe.
            if (sample >= upper) begin
              state_d = HIGH;
            end else if (sample <= lower) begin
              state_d = LOW;
            end
          end
          LOW: begin
            if (sample >= upper) begin
              state_d = HIGH;
              rise    = 1'b1;
            end
          end
          HIGH: begin
            if (sample <= lower) begin
              state_d = LOW;
            end
          end
          default: state_d = INIT;
        endcase
      end
    end
  end

endmodule

// File: rtl/fringe_comparator.sv
// Digitises the interferometer sample stream into a full-scale square wave and
// tracks rising-fringe count and fringe period for the register block.
module fringe_comparator
  import fringe_comparator_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                    SYS_aclk,
  input  logic                    SYS_aresetn,
  input  logic [FC_REG_WIDTH-1:0] FC_upper_threshold,
  input  logic [FC_REG_WIDTH-1:0] FC_lower_threshold,
  input  logic                    FC_clear,
  output logic [FC_REG_WIDTH-1:0] FC_fringe_count,
  output logic [FC_REG_WIDTH-1:0] FC_period,
  output logic                    FC_level,
  output fc_state_t               FC_state_dbg,
  fringe_comparator_if.slave      S_AXIS,
  fringe_comparator_if.master     M_AXIS
);

  localparam int W = AXIS_TDATA_WIDTH;
  localparam logic [63:0]  POS_FS64 = pos_fs(W);
  localparam logic [63:0]  NEG_FS64 = neg_fs(W);
  localparam logic [W-1:0] POS_FS   = POS_FS64[W-1:0];
  localparam logic [W-1:0] NEG_FS   = NEG_FS64[W-1:0];
  localparam logic [FC_REG_WIDTH-1:0] ACC_MAX = '1;

  logic signed [W-1:0]     upper_s;
  logic signed [W-1:0]     lower_s;
  logic signed [W-1:0]     sample_s;
  fc_state_t               state_q;
  fc_state_t               state_d;
  logic                    rise;
  logic                    thr_ok;
  logic                    sample_valid;
  logic                    have_edge;
  logic [FC_REG_WIDTH-1:0] period_acc;
  logic [FC_REG_WIDTH-1:0] period_acc_inc;
  logic [W-1:0]            level_code;
  logic                    unused_m_tready;

  assign S_AXIS.tready   = 1'b1;
  assign unused_m_tready = M_AXIS.tready;

  assign sample_valid = S_AXIS.tvalid;
  assign sample_s     = $signed(S_AXIS.tdata);
  assign upper_s      = $signed(FC_upper_threshold[W-1:0]);
  assign lower_s      = $signed(FC_lower_threshold[W-1:0]);

  schmitt_trigger #(
    .W (W)
  ) u_schmitt (
    .clk          (SYS_aclk),
    .rst_n        (SYS_aresetn),
    .sample_valid (sample_valid),
    .sample       (sample_s),
    .upper        (upper_s),
    .lower        (lower_s),
    .state_q      (state_q),
    .state_d      (state_d),
    .rise         (rise),
    .thr_ok       (thr_ok)
  );

  assign FC_level     = (state_q == HIGH);
  assign FC_state_dbg = state_q;

  // Saturate rather than wrap so a stalled signal never reports a short period.
  assign period_acc_inc = (period_acc == ACC_MAX) ? period_acc : period_acc + 1'b1;

  always_comb begin
    level_code = '0;
    unique case (state_d)
      HIGH:    level_code = POS_FS;
      LOW:     level_code = NEG_FS;
      default: level_code = '0;
    endcase
  end

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      M_AXIS.tvalid <= 1'b0;
      M_AXIS.tdata  <= '0;
    end else begin
      M_AXIS.tvalid <= sample_valid;
      if (sample_valid) begin
        M_AXIS.tdata <= level_code;
      end
    end
  end

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      FC_fringe_count <= '0;
      FC_period       <= '0;
      period_acc      <= '0;
      have_edge       <= 1'b0;
    end else if (FC_clear) begin
      // Clear takes priority over a fringe landing on the same sample.
      FC_fringe_count <= '0;
      FC_period       <= '0;
      period_acc      <= '0;
      have_edge       <= 1'b0;
    end else if (sample_valid) begin
      if (!thr_ok) begin
        have_edge <= 1'b0;
      end
      if (rise) begin
        FC_fringe_count <= FC_fringe_count + 1'b1;
        if (have_edge) begin
          FC_period <= period_acc_inc;
        end
        period_acc <= '0;
        have_edge  <= 1'b1;
      end else begin
        period_acc <= period_acc_inc;
      end
    end
  end

endmodule

// File: tb/tb_fringe_comparator.sv
// Self-checking bench for fringe_comparator: table vectors, sine stream with
// gaps, clear/fringe collision and asynchronous reset sequences.
module tb_fringe_comparator;
  import fringe_comparator_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] POS = 32'h7FFF_FFFF;
  localparam logic [W-1:0] NEG = 32'h8000_0000;

  typedef struct {
    logic [31:0]  up;
    logic [31:0]  lo;
    logic [31:0]  x;
    logic [W-1:0] ed;
    logic         el;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] up_thr;
  logic [31:0] lo_thr;
  logic        clr;
  logic [31:0] cnt;
  logic [31:0] per;
  logic        lvl;
  fc_state_t   st;

  fringe_comparator_if #(.W(W)) s_axis ();
  fringe_comparator_if #(.W(W)) m_axis ();

  fringe_comparator #(
    .AXIS_TDATA_WIDTH (W)
  ) dut (
    .SYS_aclk           (clk),
    .SYS_aresetn        (rst_n),
    .FC_upper_threshold (up_thr),
    .FC_lower_threshold (lo_thr),
    .FC_clear           (clr),
    .FC_fringe_count    (cnt),
    .FC_period          (per),
    .FC_level           (lvl),
    .FC_state_dbg       (st),
    .S_AXIS             (s_axis.slave),
    .M_AXIS             (m_axis.master)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W:0] exp_q[$];
  logic [W:0] e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && m_axis.tvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got tdata %0h expected no output", m_axis.tdata);
      end else begin
        e = exp_q.pop_front();
        chk("tdata", 64'(m_axis.tdata), 64'(e[W-1:0]));
        chk("level", 64'(lvl), 64'(e[W]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic v, input logic c, input logic [31:0] x,
                      input logic [W-1:0] ed, input logic el);
    @(negedge clk);
    s_axis.tvalid = v;
    s_axis.tdata  = x;
    clr           = c;
    if (v) exp_q.push_back({el, ed});
  endtask

  task automatic drain(input string name);
    send(1'b0, 1'b0, 32'd0, '0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fringe_pair();
    send(1'b1, 1'b0, -32'sd600, NEG, 1'b0);
    send(1'b1, 1'b0, 32'sd600, POS, 1'b1);
  endtask

  vec_t tbl[9];

  initial begin : main
    int   xi;
    real  r;
    logic lvl_m;

    tbl[0] = '{32'd100, -32'sd100, 32'd0,      '0,  1'b0};
    tbl[1] = '{32'd100, -32'sd100, 32'd150,    POS, 1'b1};
    tbl[2] = '{32'd100, -32'sd100, 32'd50,     POS, 1'b1};
    tbl[3] = '{32'd100, -32'sd100, -32'sd150,  NEG, 1'b0};
    tbl[4] = '{32'd100, -32'sd100, 32'd150,    POS, 1'b1};
    tbl[5] = '{32'd100, -32'sd100, -32'sd99,   POS, 1'b1};
    tbl[6] = '{32'd100, -32'sd100, -32'sd100,  NEG, 1'b0};
    tbl[7] = '{32'd100, -32'sd100, 32'd99,     NEG, 1'b0};
    tbl[8] = '{32'd100, -32'sd100, 32'd100,    POS, 1'b1};

    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    m_axis.tready = 1'b1;
    clr           = 1'b0;
    up_thr        = 32'h8000_0000;
    lo_thr        = 32'h7FFF_FFFF;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("rst_tdata",  64'(m_axis.tdata),  64'd0);
    chk("rst_count",  64'(cnt), 64'd0);
    chk("rst_period", 64'(per), 64'd0);
    chk("rst_level",  64'(lvl), 64'd0);
    chk("rst_state",  64'(st),  64'(INIT));
    chk("s_tready",   64'(s_axis.tready), 64'd1);
    rst_n = 1'b1;

    // Invalid thresholds: output stays zero whatever the sample.
    for (int x = -1000; x <= 1000; x += 100) send(1'b1, 1'b0, x, '0, 1'b0);
    drain("drain_invalid");
    chk("invalid_count", 64'(cnt), 64'd0);
    chk("invalid_state", 64'(st), 64'(INIT));

    // Table vectors, including samples exactly at each threshold.
    for (int i = 0; i < 9; i++) begin
      up_thr = tbl[i].up;
      lo_thr = tbl[i].lo;
      send(1'b1, 1'b0, tbl[i].x, tbl[i].ed, tbl[i].el);
    end
    drain("drain_table");
    chk("table_count",  64'(cnt), 64'd2);
    chk("table_period", 64'(per), 64'd4);

    // Sine, amplitude 1000, 64 samples per fringe, random tvalid gaps.
    up_thr = 32'd500;
    lo_thr = -32'sd500;
    send(1'b0, 1'b1, 32'd0, '0, 1'b0);
    lvl_m = 1'b1;
    for (int n = 0; n < 384; n++) begin
      if ($urandom_range(0, 3) == 0) send(1'b0, 1'b0, $urandom, '0, 1'b0);
      r  = 1000.0 * $sin(2.0 * 3.14159265358979 * n / 64.0);
      xi = int'(r);
      if (xi >= 500) lvl_m = 1'b1;
      else if (xi <= -500) lvl_m = 1'b0;
      send(1'b1, 1'b0, xi, lvl_m ? POS : NEG, lvl_m);
      if (n == 100) begin
        drain("drain_sine_mid");
        chk("sine_first_count",  64'(cnt), 64'd1);
        chk("sine_first_period", 64'(per), 64'd0);
      end
    end
    drain("drain_sine");
    chk("sine_count",  64'(cnt), 64'd5);
    chk("sine_period", 64'(per), 64'd64);

    // Clear on the same sample as a rising fringe.
    send(1'b1, 1'b1, 32'd600, POS, 1'b1);
    drain("drain_clear");
    chk("clear_count",  64'(cnt), 64'd0);
    chk("clear_period", 64'(per), 64'd0);
    fringe_pair();
    drain("drain_post_clear");
    chk("post_clear_count",  64'(cnt), 64'd1);
    chk("post_clear_period", 64'(per), 64'd0);
    fringe_pair();
    drain("drain_second");
    chk("second_count",  64'(cnt), 64'd2);
    chk("second_period", 64'(per), 64'd2);
    repeat (3) fringe_pair();
    drain("drain_five");

    // Asynchronous reset in HIGH with count 5, output beat in flight.
    @(negedge clk);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = 32'd600;
    @(posedge clk);
    #2;
    s_axis.tvalid = 1'b0;
    chk("pre_rst_count", 64'(cnt), 64'd5);
    chk("pre_rst_state", 64'(st), 64'(HIGH));
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("arst_tdata",  64'(m_axis.tdata),  64'd0);
    chk("arst_count",  64'(cnt), 64'd0);
    chk("arst_period", 64'(per), 64'd0);
    chk("arst_level",  64'(lvl), 64'd0);
    chk("arst_state",  64'(st),  64'(INIT));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, 1'b0, 32'd0, '0, 1'b0);
    drain("drain_after_rst");
    chk("after_rst_state", 64'(st), 64'(INIT));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL timeout: got no end of test expected finish before 200000ns");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
